alu_arbiter: RTL

- Shares one combinational ALU instance between two requesters: req0 is the execute stage and req1 is an auxiliary unit such as address-gen or a debug port.
- Round-robin arbitration. Per-requester valid/ready on both the request and response sides. Operands and result are registered.
- Sits between the pipeline/aux logic and the single ALU, which is instantiated beside it. The arbiter drives the ALU operand and control inputs and samples its result and zero outputs.

---
 rtl/alu_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to build saturating per-requester grant counters.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [OP_W-1:0]  op_c;
  logic             owner;
  logic             last_grant;
  logic             sel0;
  logic             sel1;
  logic             rsp_hs;

  // On contention the requester that did not win last time is chosen.
  always_comb begin
    state_nx = state;
    sel0     = 1'b0;
    sel1     = 1'b0;
    if (state == IDLE) begin
      sel0 = req0_valid && (!req1_valid || last_grant);
      sel1 = req1_valid && (!req0_valid || !last_grant);
    end
    rsp_hs = owner ? (rsp1_valid && rsp1_ready)
                   : (rsp0_valid && rsp0_ready);
    unique case (state)
      IDLE:    if (sel0 || sel1) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req0_ready  = sel0;
  assign req1_ready  = sel1;
  assign alu_a       = op_a;
  assign alu_b       = op_b;
  assign alu_control = op_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op_c        <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      state <= state_nx;
      if (sel0 || sel1) begin
        op_a       <= sel1 ? req1_a : req0_a;
        op_b       <= sel1 ? req1_b : req0_b;
        op_c       <= sel1 ? req1_op : req0_op;
        owner      <= sel1;
        last_grant <= sel1;
      end
      if (state == EXEC) begin
        if (owner) begin
          rsp1_valid  <= 1'b1;
          rsp1_result <= alu_result;
          rsp1_zero   <= alu_zero;
        end else begin
          rsp0_valid  <= 1'b1;
          rsp0_result <= alu_result;
          rsp0_zero   <= alu_zero;
        end
      end
      if (rsp0_valid && rsp0_ready) rsp0_valid <= 1'b0;
      if (rsp1_valid && rsp1_ready) rsp1_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (sel0 && gnt0_cnt != '1) gnt0_cnt <= gnt0_cnt + 1'b1;
      if (sel1 && gnt1_cnt != '1) gnt1_cnt <= gnt1_cnt + 1'b1;
    end
  end
`else
  assign gnt0_cnt = '0;
  assign gnt1_cnt = '0;
`endif

endmodule
